// File: rtl/dw_multifunc_req_ctl.sv
// dw_multifunc_req_ctl: initiator-side sequencer for a fixed-point
// multifunction evaluator. It takes one encoded request at a time, issues a
// one-hot func select and the operand, waits LATENCY cycles, captures the
// result and status, and returns them over a valid/ready response port.
// Illegal codes are answered immediately with rsp_err=1 and are not issued.
//
// Optional feature: define DW_MULTIFUNC_REQ_CTL_OPISO_EN to force fu_a to 0
// outside the wait state, so the evaluator operand is quiescent when idle.
module dw_multifunc_req_ctl #(
    parameter int         OP_WIDTH    = 24,
    parameter logic [6:0] FUNC_SELECT = 7'h7F,
    parameter int         LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_WIDTH:0]   req_a,
    input  logic [2:0]          req_code,
    output logic [OP_WIDTH:0]   fu_a,
    output logic [15:0]         fu_func,
    input  logic [OP_WIDTH+1:0] fu_z,
    input  logic                fu_status,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [OP_WIDTH+1:0] rsp_z,
    output logic                rsp_status,
    output logic                rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_WIDTH+1:0] z;
        logic                status;
        logic                err;
    } rsp_t;

    // Code 7 is reserved, so the legality mask carries a permanent 0 on top.
    localparam logic [7:0] LEGAL_MASK = {1'b0, FUNC_SELECT};
    localparam logic [3:0] LAT_CNT    = 4'(LATENCY);

    state_t              state, state_nxt;
    logic [OP_WIDTH:0]   a_q, a_nxt;
    logic [15:0]         func_q, func_nxt;
    logic [3:0]          cnt_q, cnt_nxt;
    rsp_t                rsp_q, rsp_nxt;
    logic                vld_q, vld_nxt;
    logic                code_legal;
    logic                req_hs;
    logic                rsp_hs;

    assign code_legal = LEGAL_MASK[req_code];
    assign req_ready  = (state == ST_IDLE);
    assign req_hs     = req_valid & req_ready;
    assign rsp_hs     = vld_q & rsp_ready;

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            func_q <= '0;
            cnt_q  <= '0;
            rsp_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            func_q <= func_nxt;
            cnt_q  <= cnt_nxt;
            rsp_q  <= rsp_nxt;
            vld_q  <= vld_nxt;
        end
    end

    // Next-state and next register values; everything holds by default.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        func_nxt  = func_q;
        cnt_nxt   = cnt_q;
        rsp_nxt   = rsp_q;
        vld_nxt   = vld_q;
        case (state)
            ST_IDLE: begin
                if (req_hs) begin
                    if (code_legal) begin
                        a_nxt     = req_a;
                        func_nxt  = 16'h0001 << req_code;
                        cnt_nxt   = LAT_CNT;
                        state_nxt = ST_WAIT;
                    end else begin
                        // Rejected without touching the evaluator.
                        rsp_nxt.z      = '0;
                        rsp_nxt.status = 1'b0;
                        rsp_nxt.err    = 1'b1;
                        vld_nxt        = 1'b1;
                        state_nxt      = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_nxt = cnt_q - 4'd1;
                end else begin
                    rsp_nxt.z      = fu_z;
                    rsp_nxt.status = fu_status;
                    rsp_nxt.err    = 1'b0;
                    vld_nxt        = 1'b1;
                    func_nxt       = '0;
                    state_nxt      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    vld_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                func_nxt  = '0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

`ifdef DW_MULTIFUNC_REQ_CTL_OPISO_EN
    assign fu_a = (state == ST_WAIT) ? a_q : '0;
`else
    assign fu_a = a_q;
`endif

    assign fu_func    = func_q;
    assign rsp_valid  = vld_q;
    assign rsp_z      = rsp_q.z;
    assign rsp_status = rsp_q.status;
    assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_dw_multifunc_req_ctl.sv
// Randomized self-checking bench for dw_multifunc_req_ctl. A transaction-level
// reference model tracks the one request in flight by its issue edge number
// and predicts every output each cycle.
module tb_dw_multifunc_req_ctl;

    localparam int         OPW  = 24;
    localparam logic [6:0] FSEL = 7'h37;   // codes 3 and 6 absent, 7 reserved
    localparam int         LAT  = 2;
    localparam int         NCYC = 3000;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [OPW:0]    req_a;
    logic [2:0]      req_code;
    logic [OPW:0]    fu_a;
    logic [15:0]     fu_func;
    logic [OPW+1:0]  fu_z;
    logic            fu_status;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [OPW+1:0]  rsp_z;
    logic            rsp_status;
    logic            rsp_err;

    dw_multifunc_req_ctl #(
        .OP_WIDTH   (OPW),
        .FUNC_SELECT(FSEL),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_code  (req_code),
        .fu_a      (fu_a),
        .fu_func   (fu_func),
        .fu_z      (fu_z),
        .fu_status (fu_status),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_status(rsp_status),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a request is either absent, issued at edge t_issue and
    // in the evaluator until edge t_issue+1+LAT, or sitting as a response.
    bit             m_busy;
    bit             m_resp;
    int             t_issue;
    logic [2:0]     m_code;
    logic [OPW:0]   m_a;
    logic [OPW:0]   m_last_a;
    logic [OPW+1:0] m_z;
    logic           m_st;
    logic           m_err;
    bit             m_after_rst;

    function automatic bit is_legal(input logic [2:0] code);
        logic [7:0] mask;
        mask = {1'b0, FSEL};
        return (code <= 3'd6) && mask[code];
    endfunction

    task automatic model_reset();
        m_busy      = 0;
        m_resp      = 0;
        m_last_a    = '0;
        m_z         = '0;
        m_st        = 1'b0;
        m_err       = 1'b0;
        m_after_rst = 1;
    endtask

    task automatic compare_outputs();
        bit in_eval;
        logic [OPW:0] exp_a;
        in_eval = m_busy && !m_resp;
`ifdef DW_MULTIFUNC_REQ_CTL_OPISO_EN
        exp_a = in_eval ? m_a : '0;
`else
        exp_a = m_last_a;
`endif
        check("req_ready", 64'(req_ready), 64'(!m_busy));
        check("rsp_valid", 64'(rsp_valid), 64'(m_resp));
        check("fu_func", 64'(fu_func), in_eval ? (64'd1 << m_code) : 64'd0);
        check("fu_a", 64'(fu_a), 64'(exp_a));
        if (m_resp || m_after_rst) begin
            check("rsp_z", 64'(rsp_z), 64'(m_z));
            check("rsp_status", 64'(rsp_status), 64'(m_st));
            check("rsp_err", 64'(rsp_err), 64'(m_err));
        end
    endtask

    // Advance the model across the edge numbered e, given the driven inputs.
    task automatic model_step(input int e);
        m_after_rst = 0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1;
                if (is_legal(req_code)) begin
                    t_issue  = e;
                    m_code   = req_code;
                    m_a      = req_a;
                    m_last_a = req_a;
                end else begin
                    m_resp = 1;
                    m_z    = '0;
                    m_st   = 1'b0;
                    m_err  = 1'b1;
                end
            end
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_busy = 0;
                m_resp = 0;
            end
        end else if (e == t_issue + 1 + LAT) begin
            m_resp = 1;
            m_z    = fu_z;
            m_st   = fu_status;
            m_err  = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_code  = '0;
        rsp_ready = 1'b0;
        fu_z      = '0;
        fu_status = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare_outputs();
            // Evaluator output changes every cycle so a wrong capture cycle shows.
            fu_z      = (OPW+2)'($urandom);
            fu_status = 1'($urandom);
            req_a     = (OPW+1)'($urandom);
            if (cyc < 400) begin
                // Back-to-back legal traffic with the consumer always ready.
                rst       = 1'b0;
                req_valid = 1'b1;
                rsp_ready = 1'b1;
                case ($urandom_range(0, 4))
                    0: req_code = 3'd0;
                    1: req_code = 3'd1;
                    2: req_code = 3'd2;
                    3: req_code = 3'd4;
                    default: req_code = 3'd5;
                endcase
            end else begin
                rst       = ($urandom_range(0, 99) == 0);
                req_valid = 1'($urandom);
                req_code  = 3'($urandom);
                rsp_ready = ($urandom_range(0, 9) < 6);
            end
            model_step(cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dw_multifunc_req_ctl.md
Name: dw_multifunc_req_ctl

Overview:
- Initiator-side sequencer that drives a fixed-point multifunction evaluator (reciprocal, sqrt, inverse sqrt, sin, cos, log2, exp2; one-hot func select, op_width+1 operand, op_width+2 result, status flag).
- Accepts encoded function requests over a valid/ready interface and drives the evaluator's operand and one-hot func inputs.
- Waits a fixed latency, captures z/status, and returns a response over a second valid/ready interface.
- Sits between the datapath's command source and the evaluator instance; one request in flight.

Parameters:
- OP_WIDTH, 24, evaluator operand width parameter; operand is OP_WIDTH+1 bits, result OP_WIDTH+2 bits.
- FUNC_SELECT, 127, 7-bit mask of functions built into the evaluator; bit i set = function i legal.
- LATENCY, 2, range 0..15; extra cycles from operand/func drive to a valid evaluator result (0 = combinational evaluator).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_a  input  OP_WIDTH+1  operand.
- req_code  input  3  function index: 0 recip, 1 sqrt, 2 inv-sqrt, 3 sin, 4 cos, 5 log2, 6 exp2, 7 reserved.
- fu_a  output  OP_WIDTH+1  operand to evaluator.
- fu_func  output  16  one-hot func select to evaluator.
- fu_z  input  OP_WIDTH+2  evaluator result.
- fu_status  input  1  evaluator status.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumer ready.
- rsp_z  output  OP_WIDTH+2  captured result.
- rsp_status  output  1  captured status.
- rsp_err  output  1  request rejected (illegal code).

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_z 0; rsp_status 0; rsp_err 0; fu_func 0; fu_a 0; wait counter 0.
- Reset asserted mid-operation: in-flight request dropped, no response issued, all outputs take reset values on the next edge.
- req_ready = (state==IDLE). Handshake occurs when req_valid & req_ready on a rising edge.
- Legal request: req_code <= 6 and FUNC_SELECT[req_code] = 1. Any other code is illegal.
- IDLE:
  - Legal handshake: register req_a into fu_a, set fu_func = 1 << req_code (bits 15:7 always 0), load counter = LATENCY, go to WAIT.
  - Illegal handshake: rsp_z = 0, rsp_status = 0, rsp_err = 1, rsp_valid = 1, go to RESP. The evaluator is not issued to (fu_func stays 0).
- WAIT:
  - fu_a and fu_func held stable.
  - counter != 0: decrement.
  - counter == 0: capture fu_z into rsp_z and fu_status into rsp_status, rsp_err = 0, rsp_valid = 1, fu_func = 0, go to RESP.
- RESP:
  - rsp_valid, rsp_z, rsp_status, rsp_err held until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid = 0, go to IDLE. The next request is accepted no earlier than the following cycle.
- Timing, request handshake at edge T:
  - fu_func valid in cycle T+1.
  - Capture at the edge ending cycle T+1+LATENCY.
  - rsp_valid rises at T+2+LATENCY.
  - Illegal request: rsp_valid rises at T+1.
- fu_func is 0 in IDLE and RESP (evaluator idle, low power). fu_func is never multi-hot.
- rsp_ready held high in RESP: one transaction completes every LATENCY+3 cycles.

Optional Feature:
- Macro DW_MULTIFUNC_REQ_CTL_OPISO_EN: operand isolation.
- Defined: fu_a forced to 0 whenever state != WAIT, so the evaluator inputs are quiescent when idle.
- Undefined: fu_a retains the last issued operand outside WAIT. No other behaviour differs.

Test Plan:
- Reset mid-WAIT: with LATENCY=2, assert rst one cycle after issue -> next cycle rsp_valid=0, fu_func=0, req_ready=1; no response ever appears for that request.
- Legal sqrt: req_code=1, req_a=0x0400000, fu_z model returns 0x2000000 -> fu_func=0x0002 from T+1 to T+3, rsp_valid at T+4, rsp_z=0x2000000, rsp_err=0.
- LATENCY=0 exp2: req_code=6 -> fu_func=0x0040 for exactly one cycle; rsp_valid at T+2 with fu_z/fu_status values from cycle T+1.
- Illegal codes: FUNC_SELECT=7, req_code=5 -> rsp_valid at T+1, rsp_err=1, rsp_z=0, fu_func stays 0. Also req_code=7 with FUNC_SELECT=127 -> rsp_err=1.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout, new req_valid not accepted; rsp_ready=1 -> IDLE next cycle.
- Back-to-back: 4 requests with rsp_ready=1 and LATENCY=2 -> responses in order, spaced 5 cycles; with OPISO_EN defined, fu_a=0 outside WAIT.
